seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Parametrised multiplexed seven-segment scan controller. It is the successor to the four-digit display driver. It drives up to eight common-anode digits from a packed hex bus and generates its own refresh timing, so no external refresh tick is needed. New over the fixed four-digit driver:
- inter-digit blanking (anti-ghosting)
- per-digit decimal point and blank
- optional leading-zero suppression
- frame-coherent snapshot of inputs

It sits between the clock/counter datapath and the board's anode/cathode pins.

## Interface
- N_DIGITS, 8, number of scanned digits, legal 1..8
- REFRESH_DIV, 100000, clock cycles per digit slot, legal ≥ 2
- BLANK_CYCLES, 1000, all-off cycles at the start of each slot, legal 0..REFRESH_DIV-1

Ports:
- ck  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; low = display dark, scan held at start
- digits  in  4*N_DIGITS  hex values; digit i = digits[4i+3:4i], digit 0 rightmost
- dp  in  N_DIGITS  decimal point request per digit, active high
- blank  in  N_DIGITS  force digit dark, active high
- lz_suppress  in  1  enable leading-zero suppression
- an  out  N_DIGITS  anode enables, active low, one-hot-low or all ones
- c  out  7  cathodes {ca,cb,cc,cd,ce,cf,cg}, active low
- dp_out  out  1  decimal-point cathode, active low
- frame_start  out  1  one-cycle pulse when a new snapshot becomes visible

## Operation
- Slot counter `cnt` (0..REFRESH_DIV-1) and digit select `sel` (0..N_DIGITS-1) advance only while en=1.
  - `cnt` wraps REFRESH_DIV-1 → 0.
  - On that wrap, `sel` increments, wrapping N_DIGITS-1 → 0.
- Slot phases (FSM):
  - BLANK while cnt < BLANK_CYCLES: an = all ones, c = 7'b1111111, dp_out = 1.
  - DRIVE otherwise.
  - BLANK_CYCLES = 0: BLANK never entered.
- DRIVE outputs:
  - an[sel] = 0, all other an bits = 1.
  - c = hex encoding of shadow digit `sel`. Encodings: 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100, A:0001000, b:1100000, C:0110001, d:1000010, E:0110000, F:0111000.
  - dp_out = ~shadow_dp[sel].
- Dark digit: if shadow_blank[sel] = 1, or the digit is leading-zero suppressed, DRIVE behaves as BLANK for the whole slot. Slot length is unchanged.
- Leading-zero suppression: with snapshotted lz_suppress = 1, digit i (i ≥ 1) is suppressed iff it and every digit above i are 0. Digit 0 is never suppressed.
  - dp on a suppressed digit is also dark.
  - A blanked digit counts as nonzero for suppression purposes, so it does not extend suppression.
- Snapshot (load event): digits, dp, blank and lz_suppress are copied into shadow registers on a load event. Inputs changing mid-frame have no effect until the next frame. A load event is either:
  - the first enabled cycle after en rises (including en high out of reset), with cnt = 0 and sel = 0; or
  - the cycle where cnt = REFRESH_DIV-1 and sel = N_DIGITS-1, i.e. frame wrap.
- en low:
  - cnt and sel are forced to 0 and the FSM is held in BLANK; outputs go dark from the next cycle.
  - Shadow registers are retained.
- N_DIGITS = 1: `sel` stays 0 and every slot wrap is a frame wrap.

## Timing
- All outputs are registered. Outputs in cycle t+1 reflect cnt, sel and shadow state after edge t, giving one cycle of latency from a counter/state change to the pins.
- frame_start = 1 in exactly the cycle in which the new shadow values first drive outputs, i.e. one cycle after the load edge. It is 0 otherwise.
- Frame period = N_DIGITS × REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV − BLANK_CYCLES cycles per frame.
- Reset (asynchronous, rst_n = 0) sets:
  - cnt = 0, sel = 0, FSM in BLANK;
  - shadow registers = 0, en-edge register = 0;
  - an = all ones, c = 7'b1111111, dp_out = 1, frame_start = 0.
- Reset release: no output changes until the first edge with en = 1.
- Reset asserted mid-slot: outputs are dark immediately (asynchronously).
- en falling mid-slot: the next slot starts at digit 0 with a fresh snapshot on en re-rise.

## Test plan
All scenarios use N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 unless noted.
- Reset/idle: hold rst_n = 0, then release with en = 0 for 20 cycles → an = 4'b1111, c = 7'h7F, dp_out = 1, frame_start = 0 throughout.
- Basic scan: digits = 16'h3210, en = 1.
  - frame_start pulses once per 32 cycles.
  - Per slot: 2 dark cycles, then 6 cycles of an = 1110/1101/1011/0111 with c = 0000001/1001111/0010010/0000110 respectively.
- Snapshot coherence: change digits from 16'h3210 to 16'hFFFF while sel = 1 → remaining slots of the current frame still show 2 and 3; F (0111000) appears only after the next frame_start.
- Leading zeros: digits = 16'h0050, lz_suppress = 1, dp = 4'b1000.
  - Digits 3 and 2 are dark, including dp.
  - Digit 1 shows 5, digit 0 shows 0.
  - With digits = 16'h0000, only digit 0 lights.
- Blank/dp: blank = 4'b0100, dp = 4'b0010, digits = 16'h1111 → slot 2 dark for all 8 cycles; dp_out = 0 only during slot 1's DRIVE cycles.
- en toggle and BLANK_CYCLES = 0: drop en during sel = 2 → dark next cycle. On re-rise, the scan restarts at digit 0 with frame_start one cycle after the rise edge. With BLANK_CYCLES = 0, each digit is lit for all 8 cycles.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: drives N_DIGITS common-anode digits
// from a frame-coherent snapshot of the hex bus, with inter-digit blanking and leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    ck,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     blank,
    input  logic                    lz_suppress,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              c,
    output logic                    dp_out,
    output logic                    frame_start
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SEL_MAX = SW'(N_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } phase_t;

    phase_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [SW-1:0]        sel, sel_nxt;
    logic                 en_q;
    logic                 load, load_q;
    logic                 slot_wrap, frame_wrap;

    logic [3:0]           sh_dig [N_DIGITS];
    logic [N_DIGITS-1:0]  sh_dp;
    logic [N_DIGITS-1:0]  sh_blank;
    logic                 sh_lz;
    logic [N_DIGITS-1:0]  dark;

    logic                 drive;
    logic [N_DIGITS-1:0]  an_nxt;
    logic [6:0]           c_nxt;
    logic                 dp_nxt;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'b0000001;
            4'h1: hex_seg = 7'b1001111;
            4'h2: hex_seg = 7'b0010010;
            4'h3: hex_seg = 7'b0000110;
            4'h4: hex_seg = 7'b1001100;
            4'h5: hex_seg = 7'b0100100;
            4'h6: hex_seg = 7'b0100000;
            4'h7: hex_seg = 7'b0001111;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0000100;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b1100000;
            4'hC: hex_seg = 7'b0110001;
            4'hD: hex_seg = 7'b1000010;
            4'hE: hex_seg = 7'b0110000;
            default: hex_seg = 7'b0111000;
        endcase
    endfunction

    assign slot_wrap  = (cnt == CNT_MAX);
    assign frame_wrap = slot_wrap && (sel == SEL_MAX);
    // A rising enable loads a fresh snapshot and holds the counters for that cycle,
    // so the first frame after enable has full-length slots like every other frame.
    assign load       = en && (!en_q || frame_wrap);

    always_comb begin
        cnt_nxt = cnt;
        sel_nxt = sel;
        if (!en || !en_q) begin
            cnt_nxt = '0;
            sel_nxt = '0;
        end else if (slot_wrap) begin
            cnt_nxt = '0;
            sel_nxt = (sel == SEL_MAX) ? '0 : sel + 1'b1;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_comb begin
        int nxt_i;
        nxt_i     = int'(cnt_nxt);
        state_nxt = ST_BLANK;
        if (en && (nxt_i >= BLANK_CYCLES)) begin
            state_nxt = ST_DRIVE;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_BLANK;
            cnt    <= '0;
            sel    <= '0;
            en_q   <= 1'b0;
            load_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sel    <= sel_nxt;
            en_q   <= en;
            load_q <= load;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                sh_dig[i] <= 4'h0;
            end
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_lz    <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                sh_dig[i] <= digits[4*i +: 4];
            end
            sh_dp    <= dp;
            sh_blank <= blank;
            sh_lz    <= lz_suppress;
        end
    end

    // Suppression runs down from the top digit and stops at the first nonzero or blanked digit.
    always_comb begin
        logic run;
        run  = sh_lz;
        dark = sh_blank;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            run = run && (sh_dig[i] == 4'h0) && !sh_blank[i];
            if (run) begin
                dark[i] = 1'b1;
            end
        end
    end

    always_comb begin
        drive  = en && en_q && (state == ST_DRIVE) && !dark[sel];
        an_nxt = '1;
        c_nxt  = 7'b1111111;
        dp_nxt = 1'b1;
        if (drive) begin
            an_nxt = ~(N_DIGITS'(1) << sel);
            c_nxt  = hex_seg(sh_dig[sel]);
            dp_nxt = ~sh_dp[sel];
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            an          <= '1;
            c           <= 7'b1111111;
            dp_out      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            c           <= c_nxt;
            dp_out      <= dp_nxt;
            frame_start <= load_q && en;
        end
    end

endmodule
